fixed_div_arbiter: RTL and testbench

- Shares one multi-cycle fixed-point divider among NUM_REQ requesters, such as the shading, ray-setup and texture-coordinate units.
- Arbitration is round-robin and fair; the block issues one division at a time.
- It drives the divider's strobe/valid interface and routes each quotient back to the requester that issued the operation.
- A watchdog returns an error response if the divider never asserts valid.

---
 rtl/fixed_div_arbiter_if.sv | 30 +++
 rtl/fixed_div_arbiter.sv | 152 +++++++++++++++
 tb/tb_fixed_div_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_div_arbiter_if.sv
// Requester and divider-side signal bundle for fixed_div_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fixed_div_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_q;
  logic                     rsp_err;
  logic                     div_strobe;
  logic [WIDTH-1:0]         div_a;
  logic [WIDTH-1:0]         div_b;
  logic                     div_valid;
  logic [WIDTH-1:0]         div_q;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, div_valid, div_q,
    output req_ready, rsp_valid, rsp_q, rsp_err, div_strobe, div_a, div_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, div_valid, div_q,
    input  req_ready, rsp_valid, rsp_q, rsp_err, div_strobe, div_a, div_b, busy
  );
endinterface

// File: rtl/fixed_div_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fixed-point divider among
// NUM_REQ requesters, with a watchdog that answers with an error on timeout.
module fixed_div_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                resetn,
  fixed_div_arbiter_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rsp_q;
  logic               r_rsp_err;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_div_strobe;
  logic               r_busy;

  state_t             w_state_nx;
  logic [IDX_W-1:0]   w_rr_nx;
  logic [IDX_W-1:0]   w_gnt_nx;
  logic [WIDTH-1:0]   w_op_a_nx;
  logic [WIDTH-1:0]   w_op_b_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic [WIDTH-1:0]   w_rsp_q_nx;
  logic               w_rsp_err_nx;
  logic [NUM_REQ-1:0] w_rsp_valid_nx;
  logic               w_strobe_nx;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_found;
  logic [IDX_W-1:0]   w_sel;

  // First requesting index after the last grant, wrapping modulo NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[(32'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_rr_nx        = r_rr_ptr;
    w_gnt_nx       = r_gnt_idx;
    w_op_a_nx      = r_op_a;
    w_op_b_nx      = r_op_b;
    w_cnt_nx       = r_cnt;
    w_rsp_q_nx     = r_rsp_q;
    w_rsp_err_nx   = r_rsp_err;
    w_rsp_valid_nx = '0;
    w_strobe_nx    = 1'b0;
    w_ready        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ready     = NUM_REQ'(1) << w_sel;
          w_gnt_nx    = w_sel;
          w_rr_nx     = w_sel;
          w_op_a_nx   = bus.req_a[32'(w_sel) * WIDTH +: WIDTH];
          w_op_b_nx   = bus.req_b[32'(w_sel) * WIDTH +: WIDTH];
          w_strobe_nx = 1'b1;
          w_state_nx  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nx   = '0;
        w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.div_valid) begin
          w_rsp_q_nx     = bus.div_q;
          w_rsp_err_nx   = 1'b0;
          w_rsp_valid_nx = NUM_REQ'(1) << r_gnt_idx;
          w_state_nx     = S_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rsp_q_nx     = '0;
          w_rsp_err_nx   = 1'b1;
          w_rsp_valid_nx = NUM_REQ'(1) << r_gnt_idx;
          w_state_nx     = S_RESP;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gnt_idx    <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cnt        <= '0;
      r_rsp_q      <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= '0;
      r_div_strobe <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_rr_ptr     <= w_rr_nx;
      r_gnt_idx    <= w_gnt_nx;
      r_op_a       <= w_op_a_nx;
      r_op_b       <= w_op_b_nx;
      r_cnt        <= w_cnt_nx;
      r_rsp_q      <= w_rsp_q_nx;
      r_rsp_err    <= w_rsp_err_nx;
      r_rsp_valid  <= w_rsp_valid_nx;
      r_div_strobe <= w_strobe_nx;
      r_busy       <= (w_state_nx != S_IDLE);
    end
  end

  // The grant pulse is combinational, so it is masked while reset is held
  assign bus.req_ready  = resetn ? w_ready : '0;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_q      = r_rsp_q;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.div_strobe = r_div_strobe;
  assign bus.div_a      = r_op_a;
  assign bus.div_b      = r_op_b;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_fixed_div_arbiter.sv
// Randomized bench for fixed_div_arbiter: a Q16.16 divider model with
// per-operation latency plus a transaction-level arbitration/timing model.
module tb_fixed_div_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 255;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fixed_div_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  fixed_div_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [NUM_REQ-1:0] r_valid;
  logic [WIDTH-1:0]   r_a [NUM_REQ];
  logic [WIDTH-1:0]   r_b [NUM_REQ];
  logic [NUM_REQ-1:0] acc = '0;

  // Transaction model state (written only by the monitor)
  int          last_grant = 0;
  int          g_cyc      = -1;
  int          op_end     = -1;
  int          cur_idx    = 0;
  int          cur_lat    = 1;
  bit          cur_nv     = 1'b0;
  logic [31:0] cur_a = '0, cur_b = '0, exp_q = '0;
  bit          exp_err    = 1'b0;
  logic [31:0] res_q   [NUM_REQ];
  bit          res_err [NUM_REQ];
  int          gcnt    [NUM_REQ];
  int          rcnt    [NUM_REQ];
  int          gq[$];

  // Stimulus knobs (written only by the main sequence)
  int lat_override = 0;
  bit never        = 1'b0;
  int late_req     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Q16.16 signed divide; zero divisor saturates by dividend sign
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint n, d, q;
    if (b == 32'd0) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    n = longint'($signed(a)) * 64'sd65536;
    d = longint'($signed(b));
    q = n / d;
    return q[31:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Next owner: nearest pending requester after the previous owner
  function automatic int pick();
    for (int k = 1; k <= int'(NUM_REQ); k++)
      if (r_valid[(last_grant + k) % int'(NUM_REQ)]) return (last_grant + k) % int'(NUM_REQ);
    return -1;
  endfunction

  // Divider: answers cur_lat cycles after the strobe unless in never-valid mode
  initial begin : divider
    int          cnt;
    logic [31:0] q;
    int          late_done;
    cnt = 0; q = '0; late_done = 0;
    bus.div_valid = 1'b0;
    bus.div_q     = '0;
    forever begin
      @(posedge clk); #1;
      bus.div_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.div_valid = 1'b1;
          bus.div_q     = q;
        end
      end else if (late_req != late_done) begin
        late_done     = late_req;
        bus.div_valid = 1'b1;
        bus.div_q     = 32'hDEAD_BEEF;
      end
      if (bus.div_strobe && !cur_nv) begin
        cnt = cur_lat;
        q   = ref_div(bus.div_a, bus.div_b);
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [NUM_REQ-1:0] exp_ready;
    bit                 in_op;
    bit                 strobe_exp;
    int                 p;
    cyc++;
    if (!resetn) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_q", bus.rsp_q, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_div_strobe", bus.div_strobe, 0);
      check("rst_div_a", bus.div_a, 0);
      check("rst_div_b", bus.div_b, 0);
      check("rst_busy", bus.busy, 0);
      last_grant = 0;
      g_cyc      = -1;
      op_end     = -1;
      acc        = '0;
    end else begin
      in_op      = (g_cyc >= 0) && (cyc > g_cyc) && (cyc <= op_end);
      strobe_exp = (g_cyc >= 0) && (cyc == g_cyc + 1);
      check("busy", bus.busy, in_op);
      if (bus.div_strobe || strobe_exp) check("div_strobe", bus.div_strobe, strobe_exp);
      if (in_op) begin
        check("div_a", bus.div_a, cur_a);
        check("div_b", bus.div_b, cur_b);
      end
      if (in_op && cyc == op_end) begin
        check("rsp_valid", bus.rsp_valid, onehot(cur_idx));
        check("rsp_q", bus.rsp_q, exp_q);
        check("rsp_err", bus.rsp_err, exp_err);
        res_q[cur_idx]   = bus.rsp_q;
        res_err[cur_idx] = bus.rsp_err;
        rcnt[cur_idx]++;
      end else if (bus.rsp_valid != '0) begin
        check("rsp_spurious", bus.rsp_valid, 0);
      end
      exp_ready = '0;
      p         = -1;
      if (!in_op && r_valid != '0) begin
        p         = pick();
        exp_ready = onehot(p);
      end
      if (exp_ready != '0 || bus.req_ready != '0) check("req_ready", bus.req_ready, exp_ready);
      acc = bus.req_ready;
      if (p >= 0) begin
        last_grant = p;
        g_cyc      = cyc;
        cur_idx    = p;
        cur_nv     = never;
        cur_lat    = (lat_override > 0) ? lat_override : int'($urandom_range(1, 6));
        op_end     = cur_nv ? cyc + 2 + int'(TIMEOUT) : cyc + 2 + cur_lat;
        cur_a      = r_a[p];
        cur_b      = r_b[p];
        exp_q      = cur_nv ? 32'd0 : ref_div(cur_a, cur_b);
        exp_err    = cur_nv;
        gq.push_back(p);
        gcnt[p]++;
      end
    end
  end

  task automatic drive();
    bus.req_valid = r_valid;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = r_a[i];
      bus.req_b[i*WIDTH +: WIDTH] = r_b[i];
    end
  endtask

  // Advance one cycle; requesters granted last cycle drop their request
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < int'(NUM_REQ); i++)
      if (acc[i]) r_valid[i] = 1'b0;
    drive();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((r_valid != '0 || cyc < op_end) && n < max_cyc);
    if (r_valid != '0 || cyc < op_end) check("wait_idle_bound", 0, 1);
  endtask

  task automatic grant_at(input string tag, input int pos, input int exp);
    if (gq.size() > pos) check(tag, 64'(gq[pos]), 64'(exp));
    else check(tag, 64'(-1), 64'(exp));
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    r_valid[i] = 1'b1;
    r_a[i]     = a;
    r_b[i]     = b;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, c2, r2, r0;
    r_valid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      r_a[i] = '0; r_b[i] = '0; gcnt[i] = 0; rcnt[i] = 0;
    end
    drive();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    step();

    // Single op from requester 0
    base = gq.size(); r0 = rcnt[0];
    set_req(0, 32'h0006_0000, 32'h0002_0000); drive();
    wait_idle(50);
    grant_at("single_grant", base, 0);
    check("single_rsp_count", 64'(rcnt[0] - r0), 1);
    check("single_q", res_q[0], 32'h0003_0000);
    check("single_err", res_err[0], 0);

    // All four at once: rotation 1,2,3,0 with per-requester quotients
    base = gq.size();
    set_req(0, 32'h000A_0000, 32'h0005_0000);
    set_req(1, 32'h0001_0000, 32'h0004_0000);
    set_req(2, 32'h0009_0000, 32'h0003_0000);
    set_req(3, 32'hFFFC_0000, 32'h0002_0000);
    drive();
    wait_idle(200);
    grant_at("rr_grant0", base, 1);
    grant_at("rr_grant1", base + 1, 2);
    grant_at("rr_grant2", base + 2, 3);
    grant_at("rr_grant3", base + 3, 0);
    check("rr_q0", res_q[0], 32'h0002_0000);
    check("rr_q1", res_q[1], 32'h0000_4000);
    check("rr_q2", res_q[2], 32'h0003_0000);
    check("rr_q3", res_q[3], 32'hFFFE_0000);

    // Divider never answers, then a late stray valid, then normal service
    never = 1'b1;
    set_req(1, 32'h0005_0000, 32'h0001_0000); drive();
    step();
    never = 1'b0;
    wait_idle(TIMEOUT + 50);
    check("timeout_err", res_err[1], 1);
    check("timeout_q", res_q[1], 0);
    late_req++;
    repeat (5) step();
    set_req(2, 32'h0008_0000, 32'h0004_0000); drive();
    wait_idle(50);
    check("post_timeout_q", res_q[2], 32'h0002_0000);
    check("post_timeout_err", res_err[2], 0);

    // Requester 2 withdraws while requester 0 owns the divider
    lat_override = 6;
    c2 = gcnt[2]; r2 = rcnt[2];
    set_req(0, 32'h0004_0000, 32'h0002_0000); drive();
    step();
    set_req(2, 32'h0001_0000, 32'h0001_0000); drive();
    step(); step();
    r_valid[2] = 1'b0; drive();
    wait_idle(50);
    lat_override = 0;
    check("withdraw_grants", 64'(gcnt[2] - c2), 0);
    check("withdraw_rsps", 64'(rcnt[2] - r2), 0);

    // Divide by zero passes the divider's saturated code through
    set_req(3, 32'h0001_0000, 32'h0000_0000); drive();
    wait_idle(50);
    check("div0_q", res_q[3], 32'h7FFF_FFFF);
    check("div0_err", res_err[3], 0);

    // Reset while waiting on the divider
    lat_override = 6;
    set_req(0, 32'h0003_0000, 32'h0001_0000); drive();
    repeat (3) step();
    resetn  = 1'b0;
    r_valid = '0;
    drive();
    step();
    resetn = 1'b1;
    lat_override = 0;
    repeat (10) step();
    base = gq.size();
    for (int i = 0; i < int'(NUM_REQ); i++)
      set_req(i, 32'($urandom_range(1, 255)) << 16, 32'($urandom_range(1, 15)) << 16);
    drive();
    wait_idle(200);
    grant_at("post_reset_first_grant", base, 1);

    // Random traffic with withdrawals
    for (int t = 0; t < 400; t++) begin
      step();
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!r_valid[i] && ($urandom % 4) == 0)
          set_req(i, $urandom, ($urandom % 8 == 0) ? 32'd0 : $urandom);
        else if (r_valid[i] && ($urandom % 16) == 0)
          r_valid[i] = 1'b0;
      end
      drive();
    end
    wait_idle(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
